// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Shares the core's single memory/peripheral bus port between two masters:
//   m0 is the load/store path, m1 is instruction fetch.  One transaction is
//   granted at a time and the arbiter waits for its response before granting
//   again.  A fetch response made stale by a jump is swallowed.  Fetch is
//   promoted over load/store after it has been blocked STARVE_MAX cycles.
//
//   state | meaning
//   ------+-------------------------------------------
//   IDLE  | no transaction outstanding, grant is live
//   WAIT0 | m0 transaction accepted, awaiting response
//   WAIT1 | m1 transaction accepted, awaiting response
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   m0_*                 load/store master (request/response)
//   m1_*                 fetch master (read-only request/response)
//   s_*                  shared slave port
//   jump_flag_i          flush from ctrl; kills any in-flight fetch
//   hold_flag_o          to ctrl: fetch is valid but blocked
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req_valid_i,
  output logic                m0_req_ready_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wmask_i,
  output logic                m0_rsp_valid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,

  input  logic                m1_req_valid_i,
  output logic                m1_req_ready_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  output logic                m1_rsp_valid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,

  output logic                s_req_valid_o,
  input  logic                s_req_ready_i,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic                s_we_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wmask_o,
  input  logic                s_rsp_valid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,

  input  logic                jump_flag_i,
  output logic                hold_flag_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT0 = 2'd1,
    ST_WAIT1 = 2'd2
  } state_e;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       drop_q, drop_d;

  logic grant_m0;
  logic grant_m1;
  logic accept;
  logic in_wait0;
  logic in_wait1;
  logic m1_blocked;

  // ---------------------------------------------------------------------------
  // Grant selection.  Only live in IDLE; all outputs are forced low while rst
  // is high, so the grant is suppressed there as well.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (!rst && (state_q == ST_IDLE)) begin
      if (m0_req_valid_i && m1_req_valid_i) begin
        // The counter saturates at the limit, so >= behaves as ==.
        if (starve_cnt_q >= STARVE_LIM) begin
          grant_m1 = 1'b1;
        end else begin
          grant_m0 = 1'b1;
        end
      end else if (m0_req_valid_i) begin
        grant_m0 = 1'b1;
      end else if (m1_req_valid_i) begin
        grant_m1 = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  always_comb begin
    s_req_valid_o = 1'b0;
    s_addr_o      = '0;
    s_we_o        = 1'b0;
    s_wdata_o     = '0;
    s_wmask_o     = '0;
    if (grant_m0) begin
      s_req_valid_o = 1'b1;
      s_addr_o      = m0_addr_i;
      s_we_o        = m0_we_i;
      s_wdata_o     = m0_wdata_i;
      s_wmask_o     = m0_wmask_i;
    end else if (grant_m1) begin
      // Fetch is read-only; write fields stay zero.
      s_req_valid_o = 1'b1;
      s_addr_o      = m1_addr_i;
    end
  end

  assign m0_req_ready_o = grant_m0 & s_req_ready_i;
  assign m1_req_ready_o = grant_m1 & s_req_ready_i;
  assign accept         = s_req_valid_o & s_req_ready_i;

  // ---------------------------------------------------------------------------
  // Response path.  A fetch response is suppressed if a jump was seen while it
  // was outstanding, or if the jump coincides with the response itself.
  // ---------------------------------------------------------------------------
  assign in_wait0 = !rst && (state_q == ST_WAIT0);
  assign in_wait1 = !rst && (state_q == ST_WAIT1);

  assign m0_rsp_valid_o = in_wait0 & s_rsp_valid_i;
  assign m1_rsp_valid_o = in_wait1 & s_rsp_valid_i & ~drop_q & ~jump_flag_i;
  assign m0_rdata_o     = rst ? '0 : s_rdata_i;
  assign m1_rdata_o     = rst ? '0 : s_rdata_i;

  assign m1_blocked  = !rst && m1_req_valid_i && !m1_req_ready_o;
  assign hold_flag_o = m1_blocked;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = grant_m0 ? ST_WAIT0 : ST_WAIT1;
        end
      end
      ST_WAIT0: begin
        if (s_rsp_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT1: begin
        if (s_rsp_valid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept && grant_m1) begin
      starve_cnt_d = 3'd0;
    end else if (m1_blocked && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end

    // The response closing WAIT1 also retires the drop, even when a jump
    // arrives in that very cycle (the response is masked combinationally).
    if ((state_q == ST_WAIT1) && s_rsp_valid_i) begin
      drop_d = 1'b0;
    end else if ((state_q == ST_WAIT1) && jump_flag_i) begin
      drop_d = 1'b1;
    end else if (accept && grant_m1 && jump_flag_i) begin
      drop_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 3'd0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
    end
  end

endmodule
